// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with configurable wait states and an error response.
// Optional build macro DMEM_ALIGN_CHECK_EN: when defined, a misaligned address gets an error response.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 128,
  parameter logic [31:0] ADDR_BASE   = 32'h10010000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        commit;

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             align_bad;
  logic             req_bad;
  logic             we;
  logic             unused_off;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          addr_d  = addr;
          wdata_d = wdata;
          rd_d    = mem_read;
          wr_d    = mem_write;
          cnt_d   = CNT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The access is decoded from the _d values so a zero-wait accept commits on the same edge.
  always_comb begin
    off        = addr_d - ADDR_BASE;
    in_range   = (addr_d >= ADDR_BASE) && (off < SPAN);
    idx        = off[IDX_W+1:2];
    unused_off = ^{off[31:IDX_W+2], off[1:0]};
`ifdef DMEM_ALIGN_CHECK_EN
    align_bad  = (addr_d[1:0] != 2'b00);
`else
    align_bad  = 1'b0;
`endif
    req_bad    = !in_range || align_bad || (rd_d && wr_d);
    we         = commit && wr_d && !req_bad && !rst;
    rdata_d    = rdata_q;
    err_d      = err_q;
    if (commit) begin
      err_d = req_bad;
      if (rd_d) rdata_d = req_bad ? 32'd0 : mem_q[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request payload and array contents carry no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    if (we) mem_q[idx] <= wdata_d;
  end

  assign rdata = rdata_q;
  assign ready = (state_q == S_RESP);
  assign err   = err_q && (state_q == S_RESP);
  assign busy  = (state_q != S_IDLE);

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data-memory responder serving the load/store side of the multicycle RISC-V core. Accepts a single read or write request per transaction, inserts a configurable number of wait states, performs the access on an internal RAM array, and returns data with a one-cycle `ready` strobe. Out-of-range addresses produce an error response. The core's MEM state stalls on `ready`.

## Interface
- `DEPTH_WORDS`, default 128: number of 32-bit words in the array.
- `ADDR_BASE`, default 32'h10010000: byte address of word 0.
- `WAIT_CYCLES`, default 2: wait states between accept and response, 0..15.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_read`  in  1  read request, level, sampled in IDLE.
- `mem_write`  in  1  write request, level, sampled in IDLE.
- `addr`  in  32  byte address of request.
- `wdata`  in  32  store data.
- `rdata`  out  32  load data, valid when `ready`=1 on a read, held until next read response.
- `ready`  out  1  one-cycle response strobe.
- `err`  out  1  error flag, qualified by `ready`.
- `busy`  out  1  high in WAIT and RESP.

## Operation
- States: IDLE, WAIT, RESP. Reset enters IDLE.
- IDLE: if `mem_read` or `mem_write` is high at an edge, latch `addr`, `wdata`, and op. Go to WAIT, or to RESP if WAIT_CYCLES=0. Load the wait counter with WAIT_CYCLES-1.
- WAIT: decrement the counter each cycle. When it reaches 0, go to RESP at the next edge.
- Transition into RESP commits the access at that edge. A read registers `array[idx]` into `rdata`. A write stores the latched `wdata`.
- RESP: `ready`=1 for exactly one cycle, then IDLE. Inputs are ignored in WAIT and RESP.
- Index calculation: idx = (addr − ADDR_BASE) >> 2. The address is in range iff ADDR_BASE ≤ addr < ADDR_BASE + 4·DEPTH_WORDS. Use 32-bit unsigned compare; no wrap-around aliasing.
- Out of range:
  - Read: `err`=1, `rdata` is loaded with 0.
  - Write: `err`=1, array is unchanged.
- `mem_read` and `mem_write` both high in IDLE: illegal. Respond after the normal latency with `err`=1, no array change, `rdata`=0.
- Requester clears the request in the cycle `ready` is high. A request still high in IDLE is a new transaction.
- Array contents are not reset. `rdata` is not updated by writes.

## Timing
- Request sampled at edge N. `ready` is high during the cycle after edge N+1+WAIT_CYCLES. Total latency is WAIT_CYCLES+1 cycles. Throughput is one transaction per WAIT_CYCLES+2 cycles.
- Reset values: `rdata`=0, `ready`=0, `err`=0, `busy`=0, state IDLE, counter 0.
- Reset asserted in WAIT: transaction aborted, no write committed.
- Reset asserted in RESP: write already committed, `ready` drops immediately.
- `err` is 0 whenever `ready`=0.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - `addr[1:0]` ≠ 0 is an error, handled like out-of-range: `err`=1, no write, `rdata`=0.
- Not defined:
  - `addr[1:0]` is ignored; the access goes to the containing word.
  - `err` is raised only for range or illegal-op conditions.

## Test plan
- WAIT_CYCLES=2: write 32'hDEADBEEF to 32'h10010008, then read the same address. Each `ready` pulse arrives 3 cycles after accept. Read returns 32'hDEADBEEF with `err`=0.
- WAIT_CYCLES=0: back-to-back reads of words 0 and 127 (preloaded). `ready` comes 1 cycle after each accept. Correct data each time; `busy` is low between transactions.
- Read 32'h10010200, the first word past the end: `ready` with `err`=1, `rdata`=0. Write 32'h1000FFFC: `err`=1, and a later read of word 127 is unchanged.
- Read and write both high with `addr`=32'h10010000: `err`=1, word 0 unchanged.
- Write to 32'h10010004, reset pulsed during WAIT: no `ready` pulse, all outputs 0, word 1 unchanged after re-read.
- Write to 32'h10010006:
  - With `DMEM_ALIGN_CHECK_EN`: `err`=1, word 1 unchanged.
  - Without it: `err`=0, word 1 is written.
